// File: rtl/core_instr_queue_pkg.sv
// Shared instruction-word definitions for the processor front end, the issue queue and core decode.
// The word layout is: class bit, 8-bit opcode, then three 2-bit register fields.
package core_instr_queue_pkg;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned INSTR_W = WIDTH - 1;
    localparam int unsigned DEPTH   = 4;

    // addnv reg0,reg0: the architectural no-op, also the idle value on the issue port
    localparam logic [INSTR_W-1:0] NOP_INSTR = 15'b1_0000_1011_00_00_00;

    localparam int unsigned REG_W     = 2;
    localparam int unsigned OPC_W     = 8;
    localparam int unsigned CLASS_BIT = 14;
    localparam int unsigned OPC_LSB   = 6;
    localparam int unsigned RD_LSB    = 4;
    localparam int unsigned RS1_LSB   = 2;
    localparam int unsigned RS0_LSB   = 0;

    typedef enum logic {
        CLASS_SCALAR = 1'b0,
        CLASS_VECTOR = 1'b1
    } instr_class_e;

    typedef struct packed {
        instr_class_e     cls;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs0;
    } instr_t;

    function automatic instr_t instr_fields(input logic [INSTR_W-1:0] word);
        return instr_t'(word);
    endfunction

endpackage

// File: rtl/core_instr_queue_instr_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy count and synchronous clear.
// Full/empty derive from the count; pointers simply wrap modulo DEPTH.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 15
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               wr_data,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;

    // Next-state for pointers and occupancy; clear wins over everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only observable through count
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/core_instr_queue.sv
// In-order issue queue between the instruction processor and the vector core.
// Adds NOP filtering, flush priority and the drained indication around instr_fifo.
module core_instr_queue
    import core_instr_queue_pkg::*;
#(
    parameter int unsigned       WIDTH    = core_instr_queue_pkg::WIDTH,
    parameter int unsigned       DEPTH    = core_instr_queue_pkg::DEPTH,
    parameter logic [WIDTH-2:0]  NOP      = NOP_INSTR,
    parameter bit                DROP_NOP = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [WIDTH-2:0]         in_instr,
    output logic                     stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WIDTH-2:0]         out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drained
);

    localparam int unsigned IW    = WIDTH - 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             fifo_full;
    logic             fifo_empty;
    logic [IW-1:0]    fifo_rd_data;
    logic [CNT_W-1:0] fifo_count;
    logic             drop_word;
    logic             push;
    logic             pop;

    // NOPs never reach the core when filtering is enabled
    assign drop_word = DROP_NOP && (in_instr == NOP);
    assign push      = in_valid & ~fifo_full & ~flush & ~drop_word;
    assign pop       = ~fifo_empty & out_ready & ~flush;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (IW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .clear   (flush),
        .wr_data (in_instr),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Issue-side view is purely a function of queue state, never of out_ready
    assign stall     = fifo_full;
    assign out_valid = ~fifo_empty;
    assign out_instr = fifo_empty ? NOP : fifo_rd_data;
    assign count     = fifo_count;
    assign drained   = (fifo_count == '0) & ~in_valid;

endmodule
